// File: rtl/hatch_seq.sv
// Egg-hatching sequencer: start/temperature conditioning and frame stepping for the dot-matrix
// display. Define HATCH_FAIL_EN to enable the FAIL state, fail_cnt and the fail output.
module hatch_seq #(
    parameter int unsigned TICKS_PER_STEP = 1000,
    parameter int unsigned FAIL_TICKS     = 5000,
    parameter int unsigned LAST_FRAME     = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       temp_in,
    output logic       st,
    output logic [3:0] num,
    output logic       temp,
    output logic       done,
    output logic       fail
);

    localparam int unsigned TickW = $clog2(TICKS_PER_STEP);
    localparam logic [TickW-1:0] TickLast = TickW'(TICKS_PER_STEP - 1);
    localparam logic [3:0] LastFrame = 4'(LAST_FRAME);

    if (TICKS_PER_STEP < 2) begin : g_bad_ticks
        $error("TICKS_PER_STEP must be at least 2");
    end
    if (LAST_FRAME > 15) begin : g_bad_last
        $error("LAST_FRAME must fit in 4 bits");
    end
    if (FAIL_TICKS < 1) begin : g_bad_fail
        $error("FAIL_TICKS must be at least 1");
    end

`ifdef HATCH_FAIL_EN
    localparam int unsigned FailW = $clog2(FAIL_TICKS + 1);
    localparam logic [FailW-1:0] FailLast = FailW'(FAIL_TICKS - 1);

    typedef enum logic [2:0] {StIdle, StRun, StHold, StDone, StFail} state_e;
`else
    typedef enum logic [2:0] {StIdle, StRun, StHold, StDone} state_e;
`endif

    state_e state_q, state_d;

    logic start_s1_q, start_s2_q, start_s3_q, start_rise_q, start_rise_d;
    logic temp_s1_q, temp_s2_q, temp_s3_q;

    logic [TickW-1:0] tick_q, tick_d;
    logic [3:0] num_q, num_d;
    logic st_q, st_d, temp_q, temp_d, done_q, done_d;

    // One RUN step: what tick/num/state become after a counted cycle.
    logic at_term;
    logic [TickW-1:0] step_tick;
    logic [3:0] step_num;
    state_e step_state;

`ifdef HATCH_FAIL_EN
    logic [FailW-1:0] fail_cnt_q, fail_cnt_d;
    logic fail_q, fail_d;
`endif

    // Rise pulse and temperature both get one extra stage so either input reaches the state
    // register with the same three-edge latency.
    assign start_rise_d = start_s2_q & ~start_s3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_s3_q   <= 1'b0;
            start_rise_q <= 1'b0;
            temp_s1_q    <= 1'b0;
            temp_s2_q    <= 1'b0;
            temp_s3_q    <= 1'b0;
        end else begin
            start_s1_q   <= start;
            start_s2_q   <= start_s1_q;
            start_s3_q   <= start_s2_q;
            start_rise_q <= start_rise_d;
            temp_s1_q    <= temp_in;
            temp_s2_q    <= temp_s1_q;
            temp_s3_q    <= temp_s2_q;
        end
    end

    always_comb begin
        at_term    = (tick_q == TickLast);
        step_tick  = at_term ? '0 : tick_q + TickW'(1);
        step_num   = (at_term && (num_q != LastFrame)) ? num_q + 4'd1 : num_q;
        step_state = (at_term && (num_q == LastFrame)) ? StDone : StRun;
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        num_d   = num_q;
`ifdef HATCH_FAIL_EN
        fail_cnt_d = fail_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                tick_d = '0;
                num_d  = '0;
                if (start_rise_q) state_d = StRun;
            end
            StRun: begin
                if (temp_s3_q) begin
                    state_d = StHold;
`ifdef HATCH_FAIL_EN
                    fail_cnt_d = '0;
`endif
                end else begin
                    state_d = step_state;
                    tick_d  = step_tick;
                    num_d   = step_num;
                end
            end
            StHold: begin
                if (!temp_s3_q) begin
                    // The exit cycle already counts, so a HOLD costs exactly its own length.
                    state_d = step_state;
                    tick_d  = step_tick;
                    num_d   = step_num;
`ifdef HATCH_FAIL_EN
                    fail_cnt_d = '0;
`endif
                end
`ifdef HATCH_FAIL_EN
                else if (fail_cnt_q == FailLast) begin
                    state_d = StFail;
                end else begin
                    fail_cnt_d = fail_cnt_q + FailW'(1);
                end
`endif
            end
            StDone: begin
                if (start_rise_q) begin
                    state_d = StRun;
                    tick_d  = '0;
                    num_d   = '0;
                end
            end
`ifdef HATCH_FAIL_EN
            StFail: begin
                if (start_rise_q) begin
                    state_d    = StRun;
                    tick_d     = '0;
                    num_d      = '0;
                    fail_cnt_d = '0;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        st_d   = (state_d != StIdle);
        done_d = (state_d == StDone);
`ifdef HATCH_FAIL_EN
        temp_d = (state_d == StHold) || (state_d == StFail);
        fail_d = (state_d == StFail);
`else
        temp_d = (state_d == StHold);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            tick_q  <= '0;
            num_q   <= '0;
            st_q    <= 1'b0;
            temp_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            num_q   <= num_d;
            st_q    <= st_d;
            temp_q  <= temp_d;
            done_q  <= done_d;
        end
    end

`ifdef HATCH_FAIL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_cnt_q <= '0;
            fail_q     <= 1'b0;
        end else begin
            fail_cnt_q <= fail_cnt_d;
            fail_q     <= fail_d;
        end
    end

    assign fail = fail_q;
`else
    assign fail = 1'b0;
`endif

    assign st   = st_q;
    assign num  = num_q;
    assign temp = temp_q;
    assign done = done_q;

endmodule
